shift_feed_ctrl: RTL and testbench

Front-end sequencer that sits directly upstream of `shift_register`: accepts a framed pixel stream over a valid/ready handshake and drives the delay line's `serial_in`/`shift_en`. Tracks column/row position, drains the delay line with zero fill at each line end, and flags which `serial_out` samples are real. Every accepted line therefore produces exactly LINE_WIDTH valid samples at the delay-line output.

---
 rtl/shift_feed_ctrl.sv | 133 +++++++++++++
 tb/tb_shift_feed_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_feed_ctrl.sv
// shift_feed_ctrl: feeds a framed pixel stream into a delay line, zero-flushing at each line end.
// Optional FEED_SOF_CHECK_EN: a mid-line SOF sets sticky sof_err and resynchronises to col 0.
module shift_feed_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10,
    parameter int LINE_WIDTH = 64,
    parameter int NUM_LINES  = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_sof,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] sr_data,
    output logic                  sr_shift_en,
    output logic                  tap_valid,
    output logic [(LINE_WIDTH > 1 ? $clog2(LINE_WIDTH) : 1)-1:0] col,
    output logic [(NUM_LINES > 1 ? $clog2(NUM_LINES) : 1)-1:0]   row,
    output logic                  frame_done,
    output logic                  sof_err
);
    localparam int CW     = LINE_WIDTH > 1 ? $clog2(LINE_WIDTH) : 1;
    localparam int RW     = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
    localparam int SHIFTS = LINE_WIDTH + DEPTH - 1;
    localparam int SW     = $clog2(SHIFTS + 1);

    typedef enum logic [1:0] {IDLE, LINE, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         shift_cnt, cnt_d, issue;
    logic [CW-1:0]         col_d, base_col;
    logic [RW-1:0]         row_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  shift_d, real_d, last_d;
    logic                  sr_real, sr_last;
    logic                  tap_d, done_d, err_d;
    logic                  start, resync;

    assign s_ready = (state_q != FLUSH);

    always_comb begin
        state_d  = state_q;
        col_d    = col;
        row_d    = row;
        cnt_d    = shift_cnt;
        data_d   = '0;
        shift_d  = 1'b0;
        real_d   = 1'b0;
        last_d   = 1'b0;
        err_d    = sof_err;
        // Output flags follow the shift the delay line performs this edge
        tap_d    = sr_shift_en && sr_real;
        done_d   = sr_shift_en && sr_last;
        issue    = shift_cnt + 1'b1;
        base_col = col;
        start    = 1'b0;
        resync   = 1'b0;
        unique case (state_q)
            IDLE: start = s_valid && s_sof;
            LINE: begin
`ifdef FEED_SOF_CHECK_EN
                resync = s_valid && s_sof && (col != '0);
`endif
            end
            FLUSH: begin
                shift_d = 1'b1;
                real_d  = (issue >= SW'(DEPTH));
                if (shift_cnt == SW'(SHIFTS - 1)) begin
                    cnt_d = '0;
                    if (row == RW'(NUM_LINES - 1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                        last_d  = 1'b1;
                    end else begin
                        state_d = LINE;
                        row_d   = row + 1'b1;
                    end
                end else begin
                    cnt_d = issue;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start || resync || (state_q == LINE && s_valid)) begin
            if (start || resync) begin
                issue    = SW'(1);
                base_col = '0;
                row_d    = '0;
            end
            err_d   = sof_err | resync;
            shift_d = 1'b1;
            data_d  = s_data;
            real_d  = (issue >= SW'(DEPTH));
            cnt_d   = issue;
            if (base_col == CW'(LINE_WIDTH - 1)) begin
                col_d   = '0;
                state_d = FLUSH;
            end else begin
                col_d   = base_col + 1'b1;
                state_d = LINE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_cnt   <= '0;
            col         <= '0;
            row         <= '0;
            sr_data     <= '0;
            sr_shift_en <= 1'b0;
            sr_real     <= 1'b0;
            sr_last     <= 1'b0;
            tap_valid   <= 1'b0;
            frame_done  <= 1'b0;
            sof_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt   <= cnt_d;
            col         <= col_d;
            row         <= row_d;
            sr_data     <= data_d;
            sr_shift_en <= shift_d;
            sr_real     <= real_d;
            sr_last     <= last_d;
            tap_valid   <= tap_d;
            frame_done  <= done_d;
            sof_err     <= err_d;
        end
    end
endmodule

// File: tb/tb_shift_feed_ctrl.sv
// Bench for shift_feed_ctrl: vector table, directed line/frame sequences, randomized scoreboard.
// Builds with or without FEED_SOF_CHECK_EN.
module tb_shift_feed_ctrl;
    localparam int DW = 8, DEPTH = 10, LW = 16, NL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0, s_sof = 1'b0;
    logic          s_ready, sr_shift_en, tap_valid, frame_done, sof_err;
    logic [DW-1:0] sr_data;
    logic [3:0]    col;
    logic [0:0]    row;

    shift_feed_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LINE_WIDTH(LW), .NUM_LINES(NL)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
        .s_ready(s_ready), .sr_data(sr_data), .sr_shift_en(sr_shift_en),
        .tap_valid(tap_valid), .col(col), .row(row), .frame_done(frame_done),
        .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    // Downstream delay line
    logic [DW-1:0] dl [DEPTH];
    always @(posedge clk) begin
        if (sr_shift_en) begin
            dl[0] <= sr_data;
            for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
        end
    end

    int tests = 0, fails = 0;
    int n_shift, n_tap, n_nready, n_fd, first_tap;
    logic [DW-1:0] got_q[$];

    int m_col, m_row, m_flush, m_shifts, m_frames;
    bit m_busy;
    logic [DW-1:0] mq[$];

    typedef struct {
        logic v; logic sof; logic [7:0] d;
        logic en; logic [7:0] sd; int c; logic err;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tap_valid) begin
            if (n_tap == 0) first_tap = n_shift;
            n_tap++;
            got_q.push_back(dl[DEPTH-1]);
        end
        if (sr_shift_en) n_shift++;
        if (!s_ready) n_nready++;
        if (frame_done) n_fd++;
    endtask

    task automatic clr();
        n_shift = 0; n_tap = 0; n_nready = 0; n_fd = 0; first_tap = -1;
        got_q.delete();
    endtask

    task automatic send_line(input int first, input int n, input bit sof0, input bit bub);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(first + i);
            s_sof   = sof0 && (i == 0);
            tick();
            if (bub) begin
                s_valid = 1'b0;
                s_sof   = 1'b0;
                tick();
            end
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic drain(input int n);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic chk_seq(input string name, input int exp[$]);
        chk({name, " len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            chk($sformatf("%s[%0d]", name, i), got_q[i], exp[i]);
    endtask

    task automatic rnd_step(input logic v, input logic sf, input logic [DW-1:0] d);
        logic [DW-1:0] g;
        s_valid = v;
        s_sof   = sf;
        s_data  = d;
        chk("rnd ready", s_ready, int'(m_flush == 0));
        chk("rnd col", col, m_col);
        chk("rnd row", row, m_row);
        if (m_flush > 0) begin
            m_shifts++;
            m_flush--;
            if (m_flush == 0) begin
                if (m_row == NL - 1) begin
                    m_row = 0;
                    m_busy = 0;
                    m_frames++;
                end else begin
                    m_row++;
                end
            end
        end else if (v && (m_busy || sf)) begin
            m_busy = 1;
            mq.push_back(d);
            m_shifts++;
            if (m_col == LW - 1) begin
                m_col = 0;
                m_flush = DEPTH - 1;
            end else begin
                m_col++;
            end
        end
        tick();
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (mq.size() == 0) chk("rnd tap underflow", g, -1);
            else chk("rnd tap", g, mq.pop_front());
        end
    endtask

    initial begin
        int exp[$];
        int resync_left;

        tbl[0] = '{1'b1, 1'b0, 8'hAA, 1'b0, 8'h00, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'h01, 1'b1, 8'h01, 1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h02, 1'b1, 8'h02, 2, 1'b0};
`ifdef FEED_SOF_CHECK_EN
        tbl[5] = '{1'b1, 1'b1, 8'h03, 1'b1, 8'h03, 1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1, 1'b1};
`else
        tbl[5] = '{1'b1, 1'b1, 8'h03, 1'b1, 8'h03, 3, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3, 1'b0};
`endif
        clr();

        // Reset with s_valid/s_sof asserted
        rst = 1'b1; s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h55;
        tick(); tick();
        chk("rst ready", s_ready, 1);
        chk("rst shift_en", sr_shift_en, 0);
        chk("rst sr_data", sr_data, 0);
        chk("rst tap", tap_valid, 0);
        chk("rst col", col, 0);
        chk("rst row", row, 0);
        chk("rst fdone", frame_done, 0);
        chk("rst sof_err", sof_err, 0);
        chk("rst no shifts", n_shift, 0);
        rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0;

        for (int i = 0; i < 7; i++) begin
            s_valid = tbl[i].v; s_sof = tbl[i].sof; s_data = tbl[i].d;
            tick();
            chk($sformatf("vec%0d shift_en", i), sr_shift_en, tbl[i].en);
            if (tbl[i].en) chk($sformatf("vec%0d sr_data", i), sr_data, tbl[i].sd);
            chk($sformatf("vec%0d col", i), col, tbl[i].c);
            chk($sformatf("vec%0d sof_err", i), sof_err, tbl[i].err);
        end
        s_valid = 1'b0; s_sof = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2 col", col, 0);
        chk("rst2 sof_err", sof_err, 0);

        // Line 0, continuous
        clr();
        send_line(1, LW, 1'b1, 1'b0);
        drain(40);
        chk("l0 shifts", n_shift, LW + DEPTH - 1);
        chk("l0 taps", n_tap, LW);
        chk("l0 ready low", n_nready, DEPTH - 1);
        chk("l0 first tap", first_tap, DEPTH);
        chk("l0 fdone", n_fd, 0);
        chk("l0 row", row, 1);
        exp.delete();
        for (int i = 1; i <= LW; i++) exp.push_back(i);
        chk_seq("l0 seq", exp);

        // Line 1 with bubbles, ends frame
        clr();
        send_line(17, LW, 1'b0, 1'b1);
        drain(40);
        chk("l1 shifts", n_shift, LW + DEPTH - 1);
        chk("l1 taps", n_tap, LW);
        chk("l1 fdone", n_fd, 1);
        chk("l1 row", row, 0);
        chk("l1 col", col, 0);
        exp.delete();
        for (int i = 17; i < 17 + LW; i++) exp.push_back(i);
        chk_seq("l1 seq", exp);

        // IDLE drops non-SOF sample
        clr();
        s_valid = 1'b1; s_data = 8'hAA; tick();
        drain(3);
        chk("idle drop shifts", n_shift, 0);
        chk("idle drop ready", s_ready, 1);

        // Reset on third flush cycle
        clr();
        send_line(8'h30, LW, 1'b1, 1'b0);
        tick(); tick();
        chk("mid flush ready", s_ready, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstf shift_en", sr_shift_en, 0);
        chk("rstf ready", s_ready, 1);
        chk("rstf col", col, 0);
        chk("rstf row", row, 0);
        clr();
        send_line(8'h41, LW, 1'b1, 1'b0);
        drain(40);
        chk("rstf taps", n_tap, LW);
        chk("rstf shifts", n_shift, LW + DEPTH - 1);
        exp.delete();
        for (int i = 8'h41; i < 8'h41 + LW; i++) exp.push_back(i);
        chk_seq("rstf seq", exp);
        rst = 1'b1; tick(); rst = 1'b0;

        // SOF at col 5
        send_line(1, 5, 1'b1, 1'b0);
        clr();
        s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h80; tick();
        s_sof = 1'b0;
        exp.delete();
`ifdef FEED_SOF_CHECK_EN
        chk("sof col", col, 1);
        chk("sof err", sof_err, 1);
        resync_left = LW - 1;
        for (int i = 0; i < LW; i++) exp.push_back(8'h80 + i);
`else
        chk("sof col", col, 6);
        chk("sof err", sof_err, 0);
        resync_left = LW - 6;
        for (int i = 1; i <= 5; i++) exp.push_back(i);
        for (int i = 0; i <= LW - 6; i++) exp.push_back(8'h80 + i);
`endif
        send_line(8'h81, resync_left, 1'b0, 1'b0);
        chk("sof flush ready", s_ready, 0);
        drain(40);
        chk("sof taps", n_tap, LW);
`ifdef FEED_SOF_CHECK_EN
        chk("sof first tap", first_tap, DEPTH);
        chk("sof err sticky", sof_err, 1);
`else
        chk("sof first tap", first_tap, DEPTH - 5);
        chk("sof err tied", sof_err, 0);
`endif
        chk_seq("sof seq", exp);

        // Randomized against model
        rst = 1'b1; tick(); rst = 1'b0;
        clr();
        m_col = 0; m_row = 0; m_flush = 0; m_shifts = 0; m_frames = 0; m_busy = 0;
        mq.delete();
        for (int i = 0; i < 3000; i++)
            rnd_step($urandom_range(0, 3) != 0,
                     (m_col == 0) && ($urandom_range(0, 5) == 0), DW'($urandom));
        for (int i = 0; i < 600 && m_busy; i++)
            rnd_step(1'b1, 1'b0, DW'($urandom));
        chk("rnd finished frame", int'(m_busy), 0);
        for (int i = 0; i < 20; i++)
            rnd_step(1'b0, 1'b0, 8'h00);
        chk("rnd shifts", n_shift, m_shifts);
        chk("rnd frames", n_fd, m_frames);
        chk("rnd left", mq.size(), 0);
        chk("rnd sof_err", sof_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
